// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 game-key decoder: key indices, scan codes and FSM states.
package ps2_key_pkg;

  localparam int unsigned NKEYS = 6;

  localparam logic [2:0] KEY_LEFT       = 3'd0;
  localparam logic [2:0] KEY_RIGHT      = 3'd1;
  localparam logic [2:0] KEY_UP         = 3'd2;
  localparam logic [2:0] KEY_DOWN       = 3'd3;
  localparam logic [2:0] KEY_GAME_RESET = 3'd4;
  localparam logic [2:0] KEY_ENTER      = 3'd5;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_NULL  = 8'h00;
  localparam logic [7:0] SC_ERR   = 8'hFF;

  localparam logic [7:0] MK_LEFT       = 8'h1C;
  localparam logic [7:0] MK_RIGHT      = 8'h23;
  localparam logic [7:0] MK_UP         = 8'h1D;
  localparam logic [7:0] MK_DOWN       = 8'h1B;
  localparam logic [7:0] MK_GAME_RESET = 8'h2D;
  localparam logic [7:0] MK_ENTER      = 8'h29;

  localparam logic [7:0] EX_LEFT  = 8'h6B;
  localparam logic [7:0] EX_RIGHT = 8'h74;
  localparam logic [7:0] EX_UP    = 8'h75;
  localparam logic [7:0] EX_DOWN  = 8'h72;

  // Bytes following E1 in the Pause make sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_EXT) || (code == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational lookup from (extended flag, scan code) to decoded game-key index.
module ps2_key_map
  import ps2_key_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  input  logic       en_arrows,
  output logic       hit,
  output logic [2:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = KEY_LEFT;
    if (!ext) begin
      case (code)
        MK_LEFT:       begin hit = 1'b1; idx = KEY_LEFT;       end
        MK_RIGHT:      begin hit = 1'b1; idx = KEY_RIGHT;      end
        MK_UP:         begin hit = 1'b1; idx = KEY_UP;         end
        MK_DOWN:       begin hit = 1'b1; idx = KEY_DOWN;       end
        MK_GAME_RESET: begin hit = 1'b1; idx = KEY_GAME_RESET; end
        MK_ENTER:      begin hit = 1'b1; idx = KEY_ENTER;      end
        default:       ;
      endcase
    end else if (en_arrows) begin
      case (code)
        EX_LEFT:  begin hit = 1'b1; idx = KEY_LEFT;  end
        EX_RIGHT: begin hit = 1'b1; idx = KEY_RIGHT; end
        EX_UP:    begin hit = 1'b1; idx = KEY_UP;    end
        EX_DOWN:  begin hit = 1'b1; idx = KEY_DOWN;  end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 scan-code bytes into held-key levels plus one-cycle press/release pulses.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter bit          EN_ARROWS      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_code,
  output logic [5:0] key_held,
  output logic [5:0] key_press,
  output logic [5:0] key_release,
  output logic       frame_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      eff_state;
  logic [CW-1:0] tout_cnt;
  logic [2:0]  skip_cnt;
  logic        in_prefix;
  logic        expire;
  logic        map_ext;
  logic        map_hit;
  logic [2:0]  map_idx;

  // A byte arriving on the expiry cycle is decoded as if the prefix had already been dropped.
  always_comb begin
    in_prefix = (state == ST_EXT) || (state == ST_BRK) || (state == ST_EXT_BRK);
    expire    = in_prefix && (tout_cnt == TO_LAST);
    eff_state = expire ? ST_IDLE : state;
    map_ext   = (eff_state == ST_EXT) || (eff_state == ST_EXT_BRK);
  end

  ps2_key_map u_map (
    .ext       (map_ext),
    .code      (scan_code),
    .en_arrows (EN_ARROWS),
    .hit       (map_hit),
    .idx       (map_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      tout_cnt    <= '0;
      skip_cnt    <= '0;
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      frame_err   <= 1'b0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      frame_err   <= expire;
      state       <= eff_state;

      if (rx_done_tick || expire || !in_prefix) tout_cnt <= '0;
      else                                      tout_cnt <= tout_cnt + CW'(1);

      if (rx_done_tick) begin
        case (eff_state)
          ST_IDLE: begin
            if (scan_code == SC_EXT) begin
              state <= ST_EXT;
            end else if (scan_code == SC_BRK) begin
              state <= ST_BRK;
            end else if (scan_code == SC_PAUSE) begin
              state    <= ST_SKIP;
              skip_cnt <= PAUSE_SKIP;
            end else if (!(scan_code inside {SC_ACK, SC_BAT, SC_NULL, SC_ERR})
                         && map_hit && !key_held[map_idx]) begin
              key_held[map_idx]  <= 1'b1;
              key_press[map_idx] <= 1'b1;
            end
          end
          ST_EXT: begin
            if (scan_code == SC_BRK) begin
              state <= ST_EXT_BRK;
            end else if (scan_code == SC_EXT) begin
              frame_err <= 1'b1;
            end else begin
              state <= ST_IDLE;
              if (map_hit && !key_held[map_idx]) begin
                key_held[map_idx]  <= 1'b1;
                key_press[map_idx] <= 1'b1;
              end
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            state <= ST_IDLE;
            if (is_prefix(scan_code)) begin
              frame_err <= 1'b1;
            end else if (map_hit && key_held[map_idx]) begin
              key_held[map_idx]    <= 1'b0;
              key_release[map_idx] <= 1'b1;
            end
          end
          ST_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: two decoders (arrows on/off) driven in parallel, checked against a byte-level model.
module tb_ps2_key_decoder;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] scan_code = 8'h00;

  logic [5:0] held_a, press_a, rel_a;
  logic       ferr_a;
  logic [5:0] held_b, press_b, rel_b;
  logic       ferr_b;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .EN_ARROWS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .scan_code(scan_code),
    .key_held(held_a), .key_press(press_a), .key_release(rel_a), .frame_err(ferr_a)
  );

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .EN_ARROWS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .scan_code(scan_code),
    .key_held(held_b), .key_press(press_b), .key_release(rel_b), .frame_err(ferr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] held;
    logic       ferr;
  } exp_t;

  exp_t q [2][$];
  int   checks = 0;
  int   failures = 0;

  // Model state: pending prefixes, remaining Pause bytes, held keys.
  logic [5:0] m_held [2];
  bit         m_ext  [2];
  bit         m_brk  [2];
  int         m_skip [2];
  bit         m_carry[2];

  function automatic int key_of(int m, bit ext, logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h1C: return 0;
        8'h23: return 1;
        8'h1D: return 2;
        8'h1B: return 3;
        8'h2D: return 4;
        8'h29: return 5;
        default: return -1;
      endcase
    end
    if (m == 1) return -1;
    case (c)
      8'h6B: return 0;
      8'h74: return 1;
      8'h75: return 2;
      8'h72: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_held[m] = '0; m_ext[m] = 0; m_brk[m] = 0; m_skip[m] = 0; m_carry[m] = 0;
      q[m].delete();
    end
  endtask

  // A prefix left alone for d >= T cycles is abandoned with frame_err.
  task automatic model_gap(int m, int d);
    exp_t e;
    m_carry[m] = 0;
    if ((m_ext[m] || m_brk[m]) && d >= T) begin
      m_ext[m] = 0; m_brk[m] = 0;
      if (d > T) begin
        e = '{press: '0, rel: '0, held: m_held[m], ferr: 1'b1};
        q[m].push_back(e);
      end else begin
        m_carry[m] = 1;
      end
    end
  endtask

  task automatic model_byte(int m, logic [7:0] b);
    exp_t e;
    int   k;
    bit   mk, br;
    e = '{press: '0, rel: '0, held: '0, ferr: m_carry[m]};
    k = -1; mk = 0; br = 0;
    if (m_skip[m] > 0) begin
      m_skip[m]--;
    end else if (m_brk[m]) begin
      if (b == 8'hE0 || b == 8'hF0) e.ferr = 1'b1;
      else begin k = key_of(m, m_ext[m], b); br = 1; end
      m_ext[m] = 0; m_brk[m] = 0;
    end else if (m_ext[m]) begin
      if (b == 8'hF0) m_brk[m] = 1;
      else if (b == 8'hE0) e.ferr = 1'b1;
      else begin k = key_of(m, 1, b); mk = 1; m_ext[m] = 0; end
    end else if (b == 8'hE0) begin
      m_ext[m] = 1;
    end else if (b == 8'hF0) begin
      m_brk[m] = 1;
    end else if (b == 8'hE1) begin
      m_skip[m] = 7;
    end else if (!(b inside {8'hFA, 8'hAA, 8'h00, 8'hFF})) begin
      k = key_of(m, 0, b); mk = 1;
    end
    if (k >= 0 && mk && !m_held[m][k]) begin m_held[m][k] = 1'b1; e.press[k] = 1'b1; end
    if (k >= 0 && br &&  m_held[m][k]) begin m_held[m][k] = 1'b0; e.rel[k]   = 1'b1; end
    e.held = m_held[m];
    if (e.press != 0 || e.rel != 0 || e.ferr) q[m].push_back(e);
  endtask

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic check_held(string name);
    chk({name, "_held_a"}, held_a, m_held[0]);
    chk({name, "_held_b"}, held_b, m_held[1]);
  endtask

  // d = clock edges between the previous tick and this one.
  task automatic send(logic [7:0] b, int d);
    for (int m = 0; m < 2; m++) model_gap(m, d);
    for (int i = 1; i < d; i++) begin @(posedge clk); #1; end
    for (int m = 0; m < 2; m++) model_byte(m, b);
    rx_done_tick = 1'b1;
    scan_code    = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic drain();
    for (int m = 0; m < 2; m++) model_gap(m, T + 8);
    repeat (T + 8) @(posedge clk);
    #1;
  endtask

  task automatic mon(int m, logic [5:0] p, logic [5:0] r, logic f, logic [5:0] h);
    exp_t e;
    if (p != 0 || r != 0 || f) begin
      checks++;
      if (q[m].size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse dut%0d press=%b release=%b ferr=%b", m, p, r, f);
      end else begin
        e = q[m].pop_front();
        if (p !== e.press || r !== e.rel || f !== e.ferr || h !== e.held) begin
          failures++;
          $display("FAIL scoreboard dut%0d got press=%b rel=%b ferr=%b held=%b exp press=%b rel=%b ferr=%b held=%b",
                   m, p, r, f, h, e.press, e.rel, e.ferr, e.held);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, press_a, rel_a, ferr_a, held_a);
      mon(1, press_b, rel_b, ferr_b, held_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  logic [7:0] pool [18] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D, 8'h29, 8'h6B, 8'h74, 8'h75,
                            8'h72, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h5A};

  initial begin
    int r, d;
    logic [7:0] b;
    model_reset();
    #2 reset = 1'b0;
    #2;
    chk("rst_held_a", held_a, 6'b0);
    chk("rst_pulses_a", press_a | rel_a | {5'b0, ferr_a}, 6'b0);
    chk("rst_pulses_b", press_b | rel_b | {5'b0, ferr_b}, 6'b0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Make then typematic repeats.
    send(8'h1C, 3); send(8'h1C, 3); send(8'h1C, 2);
    check_held("t1");
    chk("t1_value", held_a, 6'b000001);

    // Break of one of two held keys.
    send(8'h1C, 2); send(8'h1D, 2); send(8'hF0, 2); send(8'h1C, 1);
    chk("t2_value", held_a, 6'b000100);
    send(8'hF0, 2); send(8'h1D, 2);
    check_held("t2");

    // Extended arrows: aliasing on one instance, ignored on the other.
    send(8'hE0, 2); send(8'h74, 2);
    chk("t3_right_a", held_a, 6'b000010);
    chk("t3_right_b", held_b, 6'b000000);
    send(8'hE0, 2); send(8'hF0, 2); send(8'h74, 2);
    check_held("t3");

    // Abandoned break prefix.
    send(8'hF0, 2);
    drain();
    send(8'h29, 2);
    chk("t4_value", held_a, 6'b100000);

    // Pause sequence swallowed.
    send(8'hE1, 2); send(8'h14, 2); send(8'h77, 2); send(8'hE1, 2);
    send(8'hF0, 2); send(8'h14, 2); send(8'hF0, 2); send(8'h77, 2);
    send(8'h2D, 2);
    chk("t5_value", held_a, 6'b110000);
    send(8'hF0, 2); send(8'h29, 2); send(8'hF0, 2); send(8'h2D, 2);

    // Mid-stream reset after a dangling F0.
    send(8'h1B, 2);
    chk("t6_held", held_a, 6'b001000);
    send(8'hF0, 2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_held_a", held_a, 6'b0);
    chk("t6_rst_held_b", held_b, 6'b0);
    chk("t6_rst_pulses", press_a | rel_a | {5'b0, ferr_a}, 6'b0);
    model_reset();
    #3 reset = 1'b1;
    send(8'h1B, 2);
    check_held("t6_after");

    // Timeout boundary: T-1, exactly T, beyond T.
    send(8'hF0, 2); send(8'h1B, T - 1);
    check_held("to_below");
    send(8'h1B, 2);
    send(8'hF0, 2); send(8'h1B, T);
    check_held("to_equal");
    send(8'hE0, 2); send(8'h1C, T + 3);
    check_held("to_above");
    send(8'hE0, 2); send(8'hE0, 3); send(8'h75, 2);
    check_held("ext_ext");

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      d = T - 1;
      else if (r == 1) d = T;
      else if (r == 2) d = T + 2;
      else             d = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else                           b = pool[$urandom_range(0, 17)];
      send(b, d);
      if (n % 10 == 0) check_held("rand");
    end

    drain();
    check_held("final");
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got_left=%0d/%0d exp=0", q[0].size(), q[1].size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
